apb_nslave_master: RTL and testbench

Parametrised APB master bridge driving up to NUM_SLAVES APB completers over a shared bus with one-hot select. A simple user-side request (transfer / read_write / address / data) is accepted and turned into compliant SETUP/ACCESS phases. The bridge supports wait states (pready), slave error reporting and back-to-back transfers, and decodes the target slave from the upper address bits. It sits between the test/user request port and the APB slave fabric, replacing the fixed two-slave master.

---
 rtl/apb_nslave_master_pkg.sv | 20 ++
 rtl/apb_nslave_master_if.sv | 48 ++++
 rtl/apb_nslave_master_addr_decoder.sv | 32 +++
 rtl/apb_nslave_master.sv | 178 +++++++++++++++++
 tb/tb_apb_nslave_master.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_nslave_master_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_pkg : state encoding and default widths for apb_nslave_master |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_AW          = 9;
  localparam int DEF_DW          = 8;
  localparam int DEF_NUM_SLAVES  = 2;
  localparam int DEF_TIMEOUT_CYC = 16;

endpackage
`default_nettype wire

// File: rtl/apb_nslave_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_nslave_master_if : user request port and shared APB fabric     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface apb_nslave_master_if
  import apb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int NUM_SLAVES = DEF_NUM_SLAVES
) ();

  logic                     transfer;
  logic                     read_write;
  logic [AW-1:0]            apb_write_paddr;
  logic [DW-1:0]            apb_write_data;
  logic [AW-1:0]            apb_read_paddr;
  logic [DW-1:0]            apb_read_data_out;
  logic                     xfer_done;
  logic                     xfer_err;
  logic                     busy;

  logic [NUM_SLAVES-1:0]    psel;
  logic                     penable;
  logic                     pwrite;
  logic [AW-1:0]            paddr;
  logic [DW-1:0]            pwdata;
  logic [NUM_SLAVES*DW-1:0] prdata;
  logic [NUM_SLAVES-1:0]    pready;
  logic [NUM_SLAVES-1:0]    pslverr;

  modport master (
    input  transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr,
    input  prdata, pready, pslverr,
    output apb_read_data_out, xfer_done, xfer_err, busy,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr,
    output prdata, pready, pslverr,
    input  apb_read_data_out, xfer_done, xfer_err, busy,
    input  psel, penable, pwrite, paddr, pwdata
  );

endinterface
`default_nettype wire

// File: rtl/apb_nslave_master_addr_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_addr_decoder : upper address bits -> one-hot select + valid    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module apb_addr_decoder #(
  parameter int AW         = 9,
  parameter int NUM_SLAVES = 2
) (
  input  logic [AW-1:0]         addr_i,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic                  valid_o
);

  localparam int SEL_W = $clog2(NUM_SLAVES);

  logic [AW-1:0] w_idx;

  assign w_idx = addr_i >> (AW - SEL_W);

  // Indices at or beyond NUM_SLAVES match no slave, leaving sel_o zero.
  always_comb begin
    sel_o = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_idx == AW'(i)) sel_o[i] = 1'b1;
    end
  end

  assign valid_o = |sel_o;

endmodule
`default_nettype wire

// File: rtl/apb_nslave_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_nslave_master : APB bridge to NUM_SLAVES completers, one-hot   |
// | select. Optional ACCESS timeout enabled by macro APB_TIMEOUT_EN.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module apb_nslave_master
  import apb_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                pclk,
  input  logic                preset,
  apb_nslave_master_if.master bus
);

  apb_state_e            state_q, state_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [AW-1:0]         paddr_q, paddr_d;
  logic [DW-1:0]         pwdata_q, pwdata_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic [AW-1:0]         w_req_addr;
  logic [NUM_SLAVES-1:0] w_req_sel;
  logic                  w_req_valid;
  logic                  w_accept;
  logic                  w_ready;
  logic                  w_slverr;
  logic                  w_timeout;
  logic [DW-1:0]         w_prdata;

  assign w_req_addr = bus.read_write ? bus.apb_read_paddr : bus.apb_write_paddr;

  // Decode the incoming request so psel is already registered in SETUP.
  apb_addr_decoder #(
    .AW         (AW),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_dec (
    .addr_i  (w_req_addr),
    .sel_o   (w_req_sel),
    .valid_o (w_req_valid)
  );

  assign w_ready  = |(psel_q & bus.pready);
  assign w_slverr = |(psel_q & bus.pslverr);

  always_comb begin
    w_prdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (psel_q[i]) w_prdata = bus.prdata[i*DW +: DW];
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (w_accept) begin
      cnt_d = '0;
    end else if (state_q == ACCESS && !w_ready) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign w_timeout = (state_q == ACCESS) && !w_ready && (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
  // No timeout: ACCESS waits for pready indefinitely (constant-false term).
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    w_accept  = 1'b0;

    case (state_q)
      IDLE: begin
        w_accept = bus.transfer;
      end
      SETUP: begin
        if (|psel_q) begin
          state_d   = ACCESS;
          penable_d = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ACCESS: begin
        if (w_ready || w_timeout) begin
          done_d    = 1'b1;
          err_d     = w_timeout | w_slverr;
          if (w_ready && !pwrite_q) rdata_d = w_prdata;
          state_d   = IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          busy_d    = 1'b0;
          w_accept  = bus.transfer;
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_accept) begin
      state_d   = SETUP;
      pwrite_d  = ~bus.read_write;
      paddr_d   = w_req_addr;
      pwdata_d  = bus.apb_write_data;
      psel_d    = w_req_valid ? w_req_sel : '0;
      penable_d = 1'b0;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.psel              = psel_q;
  assign bus.penable           = penable_q;
  assign bus.pwrite            = pwrite_q;
  assign bus.paddr             = paddr_q;
  assign bus.pwdata            = pwdata_q;
  assign bus.apb_read_data_out = rdata_q;
  assign bus.xfer_done         = done_q;
  assign bus.xfer_err          = err_q;
  assign bus.busy              = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_nslave_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_apb_nslave_master : randomized transfers against a transaction  |
// | model; second instance with NUM_SLAVES=3 for decode errors.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_apb_nslave_master;
  import apb_pkg::*;

  localparam int AW   = DEF_AW;
  localparam int DW   = DEF_DW;
  localparam int NS   = DEF_NUM_SLAVES;
  localparam int TO   = DEF_TIMEOUT_CYC;
  localparam int SELW = $clog2(NS);
  localparam int PW   = NS * DW;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  apb_nslave_master_if #(.AW(AW), .DW(DW), .NUM_SLAVES(NS)) bus ();
  apb_nslave_master_if #(.AW(AW), .DW(DW), .NUM_SLAVES(3))  bus3 ();

  apb_nslave_master #(.AW(AW), .DW(DW), .NUM_SLAVES(NS), .TIMEOUT_CYC(TO)) u_dut (
    .pclk   (clk),
    .preset (rst),
    .bus    (bus.master)
  );

  apb_nslave_master #(.AW(AW), .DW(DW), .NUM_SLAVES(3), .TIMEOUT_CYC(TO)) u_dut3 (
    .pclk   (clk),
    .preset (rst),
    .bus    (bus3.master)
  );

  typedef struct {
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    bit            serr;
    logic [DW-1:0] rd;
    bit            b2b;
  } req_t;

  req_t          q[$];
  int            n_cmp = 0;
  int            n_mis = 0;
  logic [DW-1:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic req_t mk(bit rw, logic [AW-1:0] addr, logic [DW-1:0] wdata,
                              int waits, bit serr, logic [DW-1:0] rd, bit b2b);
    req_t r;
    r.rw = rw; r.addr = addr; r.wdata = wdata; r.waits = waits;
    r.serr = serr; r.rd = rd; r.b2b = b2b;
    return r;
  endfunction

  task automatic junk_req(input bit allow_xfer);
    bus.transfer        = allow_xfer ? 1'($urandom) : 1'b0;
    bus.read_write      = 1'($urandom);
    bus.apb_write_paddr = AW'($urandom);
    bus.apb_read_paddr  = AW'($urandom);
    bus.apb_write_data  = DW'($urandom);
  endtask

  task automatic present(input req_t r);
    junk_req(1'b0);
    bus.transfer   = 1'b1;
    bus.read_write = r.rw;
    if (r.rw) bus.apb_read_paddr = r.addr;
    else      bus.apb_write_paddr = r.addr;
    bus.apb_write_data = r.wdata;
  endtask

  task automatic slave_resp(input int idx, input bit rdy, input bit serr, input logic [DW-1:0] rd);
    bus.pready  = NS'($urandom);
    bus.pslverr = NS'($urandom);
    bus.prdata  = PW'($urandom);
    bus.pready[idx]            = rdy;
    bus.pslverr[idx]           = serr;
    bus.prdata[idx*DW +: DW]   = rd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_psel"},    bus.psel, 0);
    check({tag, "_penable"}, bus.penable, 0);
    check({tag, "_pwrite"},  bus.pwrite, 0);
    check({tag, "_paddr"},   bus.paddr, 0);
    check({tag, "_pwdata"},  bus.pwdata, 0);
    check({tag, "_rdata"},   bus.apb_read_data_out, 0);
    check({tag, "_done"},    bus.xfer_done, 0);
    check({tag, "_err"},     bus.xfer_err, 0);
    check({tag, "_busy"},    bus.busy, 0);
  endtask

  // Transaction model: SETUP cycle, then waits+1 ACCESS cycles (or the
  // timeout limit), then a one-cycle done; b2b requests overlap the done cycle.
  task automatic run_queue();
    req_t          cur;
    int            idx;
    int            eff;
    bit            to;
    bit            nxt_b2b;
    logic [NS-1:0] esel;
    for (int k = 0; k < q.size(); k++) begin
      cur = q[k];
      if (k == 0 || !cur.b2b) begin
        present(cur);
        tick();
        check("setup_done_low", bus.xfer_done, 0);
      end
      idx  = int'(cur.addr >> (AW - SELW));
      esel = NS'(1) << idx;
      check("setup_psel",    bus.psel, esel);
      check("setup_penable", bus.penable, 0);
      check("setup_busy",    bus.busy, 1);
      check("setup_pwrite",  bus.pwrite, !cur.rw);
      check("setup_paddr",   bus.paddr, cur.addr);
      if (!cur.rw) check("setup_pwdata", bus.pwdata, cur.wdata);
      junk_req(1'b1);
      slave_resp(idx, 1'($urandom), 1'($urandom), DW'($urandom));
      tick();

      eff = cur.waits;
      to  = 1'b0;
`ifdef APB_TIMEOUT_EN
      if (cur.waits >= TO) begin
        eff = TO - 1;
        to  = 1'b1;
      end
`endif
      nxt_b2b = (k + 1 < q.size()) && q[k+1].b2b;
      for (int c = 0; c <= eff; c++) begin
        check("access_penable",  bus.penable, 1);
        check("access_psel",     bus.psel, esel);
        check("access_done_low", bus.xfer_done, 0);
        check("access_paddr",    bus.paddr, cur.addr);
        slave_resp(idx, (c == eff) && !to, cur.serr, cur.rd);
        if (c < eff)      junk_req(1'b1);
        else if (nxt_b2b) present(q[k+1]);
        else              junk_req(1'b0);
        tick();
      end

      if (cur.rw && !to) m_rdata = cur.rd;
      check("done_pulse", bus.xfer_done, 1);
      check("done_err",   bus.xfer_err, to || cur.serr);
      check("done_rdata", bus.apb_read_data_out, m_rdata);
      if (!nxt_b2b) begin
        check("idle_busy",    bus.busy, 0);
        check("idle_psel",    bus.psel, 0);
        check("idle_penable", bus.penable, 0);
      end
    end
    q.delete();
  endtask

  initial begin
    rst     = 1'b1;
    m_rdata = '0;
    junk_req(1'b0);
    bus.pready = '0; bus.pslverr = '0; bus.prdata = '0;
    bus3.transfer = 1'b0; bus3.read_write = 1'b0;
    bus3.apb_write_paddr = '0; bus3.apb_read_paddr = '0; bus3.apb_write_data = '0;
    bus3.pready = '0; bus3.pslverr = '0; bus3.prdata = '0;
    repeat (3) tick();
    check_all_zero("reset");
    check("reset3_psel", bus3.psel, 0);
    check("reset3_busy", bus3.busy, 0);
    rst = 1'b0;

    q.push_back(mk(1'b0, 9'h005, 8'h5A, 0, 1'b0, 8'h00, 1'b0));
    q.push_back(mk(1'b1, 9'h105, 8'h00, 2, 1'b0, 8'hC3, 1'b0));
    q.push_back(mk(1'b0, 9'h011, 8'h3C, 0, 1'b0, 8'h00, 1'b0));
    q.push_back(mk(1'b1, 9'h1F0, 8'h00, 0, 1'b0, 8'h96, 1'b1));
    q.push_back(mk(1'b0, 9'h020, 8'hE7, 0, 1'b1, 8'h00, 1'b0));
    q.push_back(mk(1'b1, 9'h021, 8'h00, 0, 1'b0, 8'h4B, 1'b0));
    run_queue();

    // Three-slave instance: index 3 is undecodable, index 2 is the top slave.
    bus3.transfer = 1'b1; bus3.read_write = 1'b1; bus3.apb_read_paddr = 9'h1A5;
    tick();
    check("d3_setup_psel", bus3.psel, 0);
    check("d3_setup_busy", bus3.busy, 1);
    bus3.transfer = 1'b0;
    tick();
    check("d3_dec_done", bus3.xfer_done, 1);
    check("d3_dec_err",  bus3.xfer_err, 1);
    check("d3_dec_psel", bus3.psel, 0);
    check("d3_dec_busy", bus3.busy, 0);
    bus3.transfer = 1'b1; bus3.apb_read_paddr = 9'h100;
    tick();
    check("d3_psel2", bus3.psel, 3'b100);
    bus3.transfer = 1'b0; bus3.pready = 3'b100; bus3.pslverr = 3'b011; bus3.prdata = 24'h77_2211;
    tick();
    check("d3_penable", bus3.penable, 1);
    tick();
    check("d3_done",  bus3.xfer_done, 1);
    check("d3_err",   bus3.xfer_err, 0);
    check("d3_rdata", bus3.apb_read_data_out, 8'h77);
    bus3.pready = '0;

    // Reset while in ACCESS, with pready asserted on the same edge.
    present(mk(1'b1, 9'h1C0, 8'h00, 5, 1'b0, 8'h11, 1'b0));
    tick();
    junk_req(1'b0);
    slave_resp(1, 1'b0, 1'b0, 8'h11);
    tick();
    check("rst_mid_penable", bus.penable, 1);
    rst = 1'b1;
    slave_resp(1, 1'b1, 1'b0, 8'h11);
    tick();
    check_all_zero("rst_mid");
    m_rdata = '0;
    rst = 1'b0;
    tick();
    check("rst_after_done", bus.xfer_done, 0);
    check("rst_after_busy", bus.busy, 0);

    repeat (150) begin
      q.push_back(mk(1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, 4),
                     ($urandom_range(0, 3) == 0), DW'($urandom), 1'($urandom)));
    end
`ifdef APB_TIMEOUT_EN
    q.push_back(mk(1'b1, 9'h0AA, 8'h00, TO + 4, 1'b0, 8'h55, 1'b0));
    q.push_back(mk(1'b0, 9'h1AA, 8'h12, TO + 1, 1'b0, 8'h00, 1'b1));
    q.push_back(mk(1'b1, 9'h0AB, 8'h00, TO - 1, 1'b0, 8'h66, 1'b0));
`endif
    run_queue();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
